// File: rtl/led_flash_sched_if.sv
// led_flash_sched_if: control/status bundle between the board inputs, the pattern scheduler and the LED pins.
interface led_flash_sched_if;
  logic       start;
  logic       stop;
  logic       mode_auto;
  logic [1:0] mode_sel;
  logic [7:0] q;
  logic       busy;
  logic [1:0] phase;
  logic       done;
  modport master (output start, stop, mode_auto, mode_sel, input q, busy, phase, done);
  modport slave  (input start, stop, mode_auto, mode_sel, output q, busy, phase, done);
endinterface

// File: rtl/led_flash_sched.sv
// led_flash_sched: tick-driven LED pattern sequencer (flash, chase, fill) with single-phase or auto round-robin runs.
module led_flash_sched #(
  parameter int TICK_DIV = 25_000_000,
  parameter int STEPS    = 10,
  parameter int LOOPS    = 2
) (
  input logic              clk,
  input logic              rs,
  led_flash_sched_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(STEPS);
  localparam int LW = $clog2(LOOPS + 1);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SMAX = SW'(STEPS - 1);
  localparam logic [LW-1:0] LMAX = LW'(LOOPS - 1);
  // encoding doubles as the phase output code
  typedef enum logic [1:0] {FLASH = 2'd0, CHASE = 2'd1, FILL = 2'd2, IDLE = 2'd3} state_t;
  state_t        r_state, w_state_n, w_first, w_end;
  logic [7:0]    r_q, w_q_n, w_step_q;
  logic [PW-1:0] r_pre, w_pre_n;
  logic [SW-1:0] r_step, w_step_n;
  logic [LW-1:0] r_loop, w_loop_n;
  logic          r_auto, w_auto_n, r_done, w_done_n, w_tick, w_last;
  function automatic logic [7:0] entry(input state_t s);
    return (s == CHASE) ? 8'h01 : 8'h00;
  endfunction
  assign w_tick   = r_pre == PMAX;
  assign w_last   = r_step == SMAX;
  assign w_first  = (bus.mode_auto || bus.mode_sel == 2'd3) ? FLASH : state_t'(bus.mode_sel);
  assign w_step_q = (r_state == FLASH) ? ~r_q :
                    (r_state == CHASE) ? {r_q[6:0], r_q[7]} :
                    (r_q == 8'hFF)     ? 8'h00 : {r_q[6:0], 1'b1};
  assign w_end    = !r_auto            ? IDLE :
                    (r_state == FLASH) ? CHASE :
                    (r_state == CHASE) ? FILL :
                    (r_loop == LMAX)   ? IDLE : FLASH;
  always_comb begin
    w_state_n = r_state;
    w_q_n     = r_q;
    w_pre_n   = r_pre;
    w_step_n  = r_step;
    w_loop_n  = r_loop;
    w_auto_n  = r_auto;
    w_done_n  = 1'b0;
    if (r_state == IDLE) begin
      if (bus.start && !bus.stop) begin
        w_state_n = w_first;
        w_q_n     = entry(w_first);
        w_pre_n   = '0;
        w_step_n  = '0;
        w_loop_n  = '0;
        w_auto_n  = bus.mode_auto;
      end
    end else if (bus.stop) begin
      w_state_n = IDLE;
      w_q_n     = 8'h00;
      w_pre_n   = '0;
      w_step_n  = '0;
      w_loop_n  = '0;
    end else if (w_tick) begin
      w_pre_n = '0;
      if (!w_last) begin
        w_step_n = r_step + SW'(1);
        w_q_n    = w_step_q;
      end else begin
        // tick STEPS closes the phase without a step update
        w_state_n = w_end;
        w_q_n     = entry(w_end);
        w_step_n  = '0;
        w_loop_n  = (r_state == FILL) ? r_loop + LW'(1) : r_loop;
        if (w_end == IDLE) begin
          w_done_n = 1'b1;
          w_loop_n = '0;
        end
      end
    end else begin
      w_pre_n = r_pre + PW'(1);
    end
  end
  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      r_state <= IDLE;
      r_q     <= 8'h00;
      r_pre   <= '0;
      r_step  <= '0;
      r_loop  <= '0;
      r_auto  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_q     <= w_q_n;
      r_pre   <= w_pre_n;
      r_step  <= w_step_n;
      r_loop  <= w_loop_n;
      r_auto  <= w_auto_n;
      r_done  <= w_done_n;
    end
  end
  assign bus.q     = r_q;
  assign bus.busy  = r_state != IDLE;
  assign bus.phase = r_state;
  assign bus.done  = r_done;
endmodule
